// File: rtl/cpu_pkg.sv
// Shared CPU definitions: requester owner encoding, default bus widths, opcodes.
package cpu_pkg;

    // Memory owner encoding used by the arbiter's round-robin state
    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 32;

    // Base opcode field values (instr[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_AMO    = 7'b0101111;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Round-robin on contention, one access per cycle, data-side lock for atomics.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                resetn,
    // Fetch port
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    // Load/store port
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_wmask,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic                d_lock,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    // Memory side
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    owner_e r_last_owner;
    logic   r_lock_active;
    logic   r_rv_i;
    logic   r_rv_d;

    logic   w_i_gnt;
    logic   w_d_gnt;

    // Grant decision: data wins when fetch idle, lock held, or fetch had the last turn
    always_comb begin
        w_i_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (resetn) begin
            w_d_gnt = d_req & (~i_req | r_lock_active | (r_last_owner == OWNER_I));
            w_i_gnt = i_req & ~r_lock_active & (~d_req | (r_last_owner == OWNER_D));
        end
    end

    // Memory command from the winner; a zero-mask store is an access with no writes
    always_comb begin
        mem_en    = w_i_gnt | w_d_gnt;
        mem_we    = '0;
        mem_addr  = i_addr;
        mem_wdata = d_wdata;
        if (w_d_gnt) begin
            mem_addr = d_addr;
            if (d_we) begin
                mem_we = d_wmask;
            end
        end
    end

    // Ownership, lock and read-return tracking; reset drops any in-flight read
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_last_owner  <= OWNER_D;
            r_lock_active <= 1'b0;
            r_rv_i        <= 1'b0;
            r_rv_d        <= 1'b0;
        end else begin
            if (w_i_gnt) begin
                r_last_owner <= OWNER_I;
            end else if (w_d_gnt) begin
                r_last_owner <= OWNER_D;
            end
            r_lock_active <= d_lock & (r_lock_active | w_d_gnt);
            r_rv_i        <= w_i_gnt;
            r_rv_d        <= w_d_gnt & ~d_we;
        end
    end

    assign i_gnt    = w_i_gnt;
    assign d_gnt    = w_d_gnt;
    assign i_rvalid = r_rv_i;
    assign d_rvalid = r_rv_d;
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural one-cycle-latency memory.
module tb_mem_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          resetn;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [3:0]    d_wmask;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_lock;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] mem [256];

    int n_vec;
    int n_err;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_wmask   (d_wmask),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_lock    (d_lock),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port memory, read data one cycle after the access
    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_wmask = '0;
        d_addr  = '0;
        d_wdata = '0;
        d_lock  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        i_req  = 1'b1;
        d_req  = 1'b1;
        next_cycle();
        @(negedge clk);
        n_vec++;
        if (i_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset_gnt: got i_gnt=%b d_gnt=%b mem_en=%b want 0 0 0",
                     i_gnt, d_gnt, mem_en);
        end
        next_cycle();
        idle_inputs();
        resetn = 1'b1;
        @(negedge clk);
        n_vec++;
        if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || mem_en !== 1'b0 || mem_we !== 4'h0) begin
            n_err++;
            $display("FAIL reset_out: got i_rv=%b d_rv=%b en=%b we=%h want 0 0 0 0",
                     i_rvalid, d_rvalid, mem_en, mem_we);
        end
    endtask

    task automatic test_single_fetch();
        // Preload MEM[5] through the data port
        next_cycle();
        d_req = 1'b1; d_we = 1'b1; d_wmask = 4'hF; d_addr = 8'h05; d_wdata = 32'h0010_0093;
        next_cycle();
        idle_inputs();
        i_req  = 1'b1;
        i_addr = 8'h05;
        @(negedge clk);
        n_vec++;
        if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 8'h05
            || mem_we !== 4'h0) begin
            n_err++;
            $display("FAIL fetch_gnt: got gnt=%b/%b en=%b addr=%h we=%h want 1/0 1 05 0",
                     i_gnt, d_gnt, mem_en, mem_addr, mem_we);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_vec++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'h0010_0093 || d_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_data: got i_rv=%b i_rdata=%h d_rv=%b want 1 00100093 0",
                     i_rvalid, i_rdata, d_rvalid);
        end
    endtask

    task automatic test_contention();
        logic          exp_i;
        logic          prev_i;
        logic [AW-1:0] exp_addr;
        next_cycle();
        resetn = 1'b0;
        idle_inputs();
        next_cycle();
        resetn = 1'b1;
        i_req  = 1'b1;
        i_addr = 8'h20;
        d_req  = 1'b1;
        d_addr = 8'h30;
        prev_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_i    = (k % 2 == 0);
            exp_addr = exp_i ? 8'h20 : 8'h30;
            @(negedge clk);
            n_vec++;
            if (i_gnt !== exp_i || d_gnt !== !exp_i || mem_addr !== exp_addr) begin
                n_err++;
                $display("FAIL contention_%0d: got i=%b d=%b addr=%h want i=%b d=%b addr=%h",
                         k, i_gnt, d_gnt, mem_addr, exp_i, !exp_i, exp_addr);
            end
            if (k > 0) begin
                n_vec++;
                if (i_rvalid !== prev_i || d_rvalid !== !prev_i) begin
                    n_err++;
                    $display("FAIL contention_rv_%0d: got i_rv=%b d_rv=%b want %b %b",
                             k, i_rvalid, d_rvalid, prev_i, !prev_i);
                end
            end
            prev_i = exp_i;
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_store_load();
        next_cycle();
        d_req = 1'b1; d_we = 1'b1; d_wmask = 4'hF; d_addr = 8'h10; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_vec++;
        if (d_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 4'hF || mem_addr !== 8'h10
            || mem_wdata !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL store_cmd: got gnt=%b en=%b we=%h addr=%h wd=%h want 1 1 f 10 deadbeef",
                     d_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        next_cycle();
        d_we = 1'b0;
        @(negedge clk);
        n_vec++;
        if (d_gnt !== 1'b1 || d_rvalid !== 1'b0 || mem_we !== 4'h0) begin
            n_err++;
            $display("FAIL store_norv: got gnt=%b d_rv=%b we=%h want 1 0 0",
                     d_gnt, d_rvalid, mem_we);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_vec++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL load_full: got d_rv=%b d_rdata=%h want 1 deadbeef", d_rvalid, d_rdata);
        end
        d_req = 1'b1; d_we = 1'b1; d_wmask = 4'h1; d_addr = 8'h10; d_wdata = 32'h0000_0011;
        next_cycle();
        d_we = 1'b0;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_vec++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEAD_BE11) begin
            n_err++;
            $display("FAIL load_byte: got d_rv=%b d_rdata=%h want 1 deadbe11", d_rvalid, d_rdata);
        end
    endtask

    task automatic test_lock();
        next_cycle();
        // Fetch alone first so data owns the next contention
        i_req  = 1'b1;
        i_addr = 8'h40;
        @(negedge clk);
        n_vec++;
        if (i_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL lock_pre: got i_gnt=%b want 1", i_gnt);
        end
        next_cycle();
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h50; d_lock = 1'b1;
        @(negedge clk);
        n_vec++;
        if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin
            n_err++;
            $display("FAIL lock_load: got d=%b i=%b want 1 0", d_gnt, i_gnt);
        end
        next_cycle();
        d_we = 1'b1; d_wmask = 4'hF; d_wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        n_vec++;
        if (d_gnt !== 1'b1 || i_gnt !== 1'b0 || d_rvalid !== 1'b1) begin
            n_err++;
            $display("FAIL lock_store: got d=%b i=%b d_rv=%b want 1 0 1", d_gnt, i_gnt, d_rvalid);
        end
        next_cycle();
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        n_vec++;
        if (i_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_en !== 1'b0) begin
            n_err++;
            $display("FAIL lock_hold: got i=%b d=%b en=%b want 0 0 0", i_gnt, d_gnt, mem_en);
        end
        next_cycle();
        d_lock = 1'b0;
        @(negedge clk);
        n_vec++;
        if (i_gnt !== 1'b0) begin
            n_err++;
            $display("FAIL lock_release_cycle: got i_gnt=%b want 0", i_gnt);
        end
        next_cycle();
        @(negedge clk);
        n_vec++;
        if (i_gnt !== 1'b1 || mem_addr !== 8'h40) begin
            n_err++;
            $display("FAIL lock_after: got i_gnt=%b addr=%h want 1 40", i_gnt, mem_addr);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        next_cycle();
        i_req  = 1'b1;
        i_addr = 8'h05;
        @(negedge clk);
        n_vec++;
        if (i_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL midrd_gnt: got i_gnt=%b want 1", i_gnt);
        end
        // Reset low in time for the next edge; the granted fetch must not return
        resetn = 1'b0;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_vec++;
        if (i_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL midrd_rv: got i_rvalid=%b want 0", i_rvalid);
        end
        next_cycle();
        resetn = 1'b1;
        i_req  = 1'b1; i_addr = 8'h06;
        d_req  = 1'b1; d_addr = 8'h07;
        @(negedge clk);
        n_vec++;
        if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_addr !== 8'h06) begin
            n_err++;
            $display("FAIL midrd_first: got i=%b d=%b addr=%h want 1 0 06", i_gnt, d_gnt, mem_addr);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_idle_zero_mask();
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge clk);
            n_vec++;
            if (mem_en !== 1'b0 || mem_we !== 4'h0) begin
                n_err++;
                $display("FAIL idle_%0d: got en=%b we=%h want 0 0", k, mem_en, mem_we);
            end
        end
        next_cycle();
        d_req = 1'b1; d_we = 1'b1; d_wmask = 4'h0; d_addr = 8'h10; d_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        n_vec++;
        if (d_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 4'h0) begin
            n_err++;
            $display("FAIL zmask_cmd: got gnt=%b en=%b we=%h want 1 1 0", d_gnt, mem_en, mem_we);
        end
        next_cycle();
        d_we = 1'b0;
        @(negedge clk);
        n_vec++;
        if (d_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL zmask_norv: got d_rvalid=%b want 0", d_rvalid);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_vec++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEAD_BE11) begin
            n_err++;
            $display("FAIL zmask_mem: got d_rv=%b d_rdata=%h want 1 deadbe11", d_rvalid, d_rdata);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        resetn = 1'b0;
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_contention();
        test_store_load();
        test_lock();
        test_reset_mid_read();
        test_idle_zero_mask();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the CPU's single-port word memory between the instruction-fetch requester and the load/store requester. Issues at most one memory access per cycle, arbitrates round-robin on contention, routes the one-cycle-latency read data back to the owner, and supports a data-side lock for atomic read-modify-write. It sits between the multi-cycle CPU control/datapath and the memory array.

## Interface

**Parameters**
- ADDR_W, 8, word-address width (256 words)
- DATA_W, 32, data width; byte-enable width is DATA_W/8

**Ports**
- clk  in  1  clock; all state updates on the rising edge
- resetn  in  1  reset, synchronous, active-low
- i_req  in  1  fetch request; held with i_addr until i_gnt
- i_addr  in  ADDR_W  fetch word address
- i_gnt  out  1  fetch accepted this cycle (combinational)
- i_rvalid  out  1  fetch data valid on i_rdata (registered)
- i_rdata  out  DATA_W  equals mem_rdata
- d_req  in  1  data request; held with payload until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_wmask  in  DATA_W/8  store byte enables
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_lock  in  1  keep the memory for the data port after its grant
- d_gnt  out  1  data access accepted this cycle (combinational)
- d_rvalid  out  1  load data valid on d_rdata (registered)
- d_rdata  out  DATA_W  equals mem_rdata
- mem_en  out  1  memory access strobe
- mem_we  out  DATA_W/8  byte write enables
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_en with mem_we == 0

## Operation
- State: last_owner (I/D), lock_active, rv_i and rv_d (read-return registers).
- Grant rules, evaluated each cycle with resetn high:
  - d_gnt = d_req & (~i_req | lock_active | last_owner==I).
  - i_gnt = i_req & ~lock_active & (~d_req | last_owner==D).
  - Both grants are never 1 in the same cycle.
- Winner drives the memory: mem_en=1, mem_addr comes from the winner's address. For a store, mem_we = d_wmask and mem_wdata = d_wdata. For a fetch or load, mem_we = 0.
- A store with d_wmask = 0 is still granted. It drives mem_en=1, mem_we=0 and does not raise d_rvalid.
- No grant in a cycle: mem_en=0, mem_we=0.
- last_owner updates to the winner on every grant and holds otherwise.
- Lock:
  - lock_active <= d_lock & (lock_active | d_gnt).
  - While lock_active is set, fetch is blocked even if d_req is low.
  - Lock releases on the first cycle d_lock is sampled low.
- Read return: rv_i <= i_gnt; rv_d <= d_gnt & ~d_we. Outputs are i_rvalid = rv_i and d_rvalid = rv_d.
- Reset (resetn low at an edge):
  - last_owner <= D, so fetch wins the first contention.
  - lock_active, rv_i, rv_d <= 0.
  - While resetn is low, i_gnt, d_gnt and mem_en are forced to 0.
  - A read granted the cycle before reset returns no rvalid.

## Timing
- Grant has zero-cycle latency from req (combinational).
- Read data returns exactly 1 cycle after grant. There is no other latency.
- Throughput is 1 access per cycle. Back-to-back grants to the same port are allowed when the other port is idle.
- Under continuous contention without lock, grants alternate I, D, I, D…
- A requester whose req is high and not granted must hold its payload. Changing the payload before grant is a protocol violation and is not checked.
- Outputs after reset: i_gnt=0, d_gnt=0, i_rvalid=0, d_rvalid=0, mem_en=0, mem_we=0. mem_addr and mem_wdata are don't-care while mem_en=0.

## Structure
- Shared package cpu_pkg holds:
  - owner encoding (OWNER_I=0, OWNER_D=1)
  - default ADDR_W/DATA_W constants
  - existing opcode constants
- Single flat module. No sub-module is warranted.

## Test plan
- Single fetch: i_req=1, i_addr=0x05, MEM[5]=0x00100093 → i_gnt=1 in the same cycle; next cycle i_rvalid=1, i_rdata=0x00100093; d_rvalid stays 0.
- Contention after reset: i_req=d_req=1 held for 4 grants → grant order I, D, I, D; mem_addr follows the winner each cycle.
- Store then load: d_we=1, d_addr=0x10, d_wmask=0xF, d_wdata=0xDEADBEEF; then load from 0x10 → the store gives d_gnt with no d_rvalid; the load gives d_rvalid with d_rdata=0xDEADBEEF. Then a store with d_wmask=0x1, d_wdata=0x11 followed by a load → 0xDEADBE11.
- Lock: d_lock=1 with a load granted, i_req=1 throughout, then a store, then d_lock=0 → i_gnt stays 0 for every cycle lock_active=1; i_gnt=1 in the cycle after d_lock is sampled low.
- Reset mid-read: fetch granted in cycle N, resetn=0 sampled at edge N+1 → i_rvalid=0 in cycle N+1. After release, the first contention grants I.
- Idle/zero-mask: no req for 3 cycles → mem_en=0. A store with d_wmask=0 → mem_en=1, mem_we=0, memory unchanged, d_rvalid=0.
